// File: rtl/bvinv_pkg.sv
// rtl/bvinv_pkg.sv - shared types and helpers for the shift-invertibility witness search
package bvinv_pkg;

  typedef enum logic [1:0] {ASHR = 2'd0, LSHR = 2'd1, SHL = 2'd2, RSVD = 2'd3} shop_e;

  typedef enum logic [2:0] {
    SGE = 3'd0, SGT = 3'd1, SLE = 3'd2, SLT = 3'd3,
    UGE = 3'd4, UGT = 3'd5, ULE = 3'd6, ULT = 3'd7
  } pred_e;

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_e;

  // Increment v, saturating at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bvshift_pred_eval.sv
// rtl/bvshift_pred_eval.sv - combinational shift + predicate evaluation for one candidate amount
module bvshift_pred_eval
  import bvinv_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = $clog2(W + 2)
) (
  input  logic [W-1:0]     s,
  input  logic [CNT_W-1:0] amt,
  input  logic [1:0]       op,
  input  logic [2:0]       pred,
  input  logic [W-1:0]     t,
  output logic             hit
);

  logic [W-1:0] r;
  logic         sat;

  always_comb begin
    sat = (amt >= CNT_W'(W));
    // Amounts of W or more collapse to the fully shifted-out value.
    case (shop_e'(op))
      LSHR:    r = sat ? '0 : (s >> amt);
      SHL:     r = sat ? '0 : (s << amt);
      default: r = sat ? {W{s[W-1]}} : W'($signed(s) >>> amt);
    endcase
  end

  always_comb begin
    hit = 1'b0;
    case (pred_e'(pred))
      SGE:     hit = $signed(r) >= $signed(t);
      SGT:     hit = $signed(r) >  $signed(t);
      SLE:     hit = $signed(r) <= $signed(t);
      SLT:     hit = $signed(r) <  $signed(t);
      UGE:     hit = r >= t;
      UGT:     hit = r >  t;
      ULE:     hit = r <= t;
      ULT:     hit = r <  t;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/bvshift_inv_search.sv
// rtl/bvshift_inv_search.sv - sequential minimal-witness search over shift amounts 0..W
module bvshift_inv_search
  import bvinv_pkg::*;
#(
  parameter int  W      = 4,
  parameter int  STAT_W = 16,
  localparam int CNT_W  = $clog2(W + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [W-1:0]      req_s,
  input  logic [W-1:0]      req_t,
  input  logic [1:0]        req_op,
  input  logic [2:0]        req_pred,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_found,
  output logic [W-1:0]      rsp_x,
  output logic [CNT_W-1:0]  rsp_iter,
  output logic [STAT_W-1:0] stat_hit,
  output logic [STAT_W-1:0] stat_miss
);

  state_e           state;
  logic [CNT_W-1:0] k;
  logic [W-1:0]     s_q;
  logic [W-1:0]     t_q;
  logic [1:0]       op_q;
  logic [2:0]       pred_q;
  logic             hit;

  bvshift_pred_eval #(.W(W), .CNT_W(CNT_W)) u_eval (
    .s    (s_q),
    .amt  (k),
    .op   (op_q),
    .pred (pred_q),
    .t    (t_q),
    .hit  (hit)
  );

  assign req_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      s_q       <= '0;
      t_q       <= '0;
      op_q      <= '0;
      pred_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_found <= 1'b0;
      rsp_x     <= '0;
      rsp_iter  <= '0;
      stat_hit  <= '0;
      stat_miss <= '0;
    end else if (flush) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            s_q    <= req_s;
            t_q    <= req_t;
            op_q   <= req_op;
            pred_q <= req_pred;
            k      <= '0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            rsp_x     <= W'(k);
            rsp_found <= 1'b1;
            rsp_iter  <= k + CNT_W'(1);
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else if (k == CNT_W'(W)) begin
            rsp_x     <= '0;
            rsp_found <= 1'b0;
            rsp_iter  <= CNT_W'(W + 1);
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + CNT_W'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
            if (rsp_found) stat_hit <= STAT_W'(sat_inc(32'(stat_hit), STAT_W));
            else           stat_miss <= STAT_W'(sat_inc(32'(stat_miss), STAT_W));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
